// File: rtl/bram_sdp_pkg.sv
// Shared types and constants for the BRAM_SDP burst read engine.
// FIFO entries are packed as {last, data}; entry_width() gives their width.
package bram_sdp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int FIFO_DEPTH = 2;

    function automatic int entry_width(input int dwidth);
        return dwidth + 1;
    endfunction

endpackage

// File: rtl/bram_rd_skid.sv
// Two-entry FIFO holding returned read words; entry 0 is the registered head.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module bram_rd_skid
    import bram_sdp_pkg::*;
#(
    parameter int W = 37
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [1:0]   count_o,
    output logic [W-1:0] head_o
);

    localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

    logic [W-1:0] e0_q, e0_d;
    logic [W-1:0] e1_q, e1_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop_i && (cnt_q != 2'd0);
    assign do_push = push_i && ((cnt_q != FULL) || do_pop);

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10: begin
                if (cnt_q == 2'd0) e0_d = push_data_i;
                else               e1_d = push_data_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                // Count is unchanged; the new word lands behind whatever remains.
                if (cnt_q == 2'd1) begin
                    e0_d = push_data_i;
                end else begin
                    e0_d = e1_q;
                    e1_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign head_o  = e0_q;

endmodule

// File: rtl/bram_sdp_stream_reader.sv
// Burst read engine for a BRAM_SDP read port (rce/ra, one-cycle latency) feeding a
// valid/ready stream. Define BRAM_RDR_STRIDE_EN to add a per-command address stride.
//
// Handshakes: a transfer happens on any rising edge where valid and ready are both
// high; valid never waits on ready, and data/last hold while valid && !ready.
module bram_sdp_stream_reader
    import bram_sdp_pkg::*;
#(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 36
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [AWIDTH:0]   cmd_len,
`ifdef BRAM_RDR_STRIDE_EN
    input  logic [AWIDTH-1:0] cmd_stride,
`endif
    output logic              rce,
    output logic [AWIDTH-1:0] ra,
    input  logic [DWIDTH-1:0] rq,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state_o
);

    localparam int EW = entry_width(DWIDTH);

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [AWIDTH:0]   rem_q, rem_d;
    logic              inflight_q;
    logic              last_q;
    logic              cmd_ready_q;
    logic              busy_q;
    logic              done_q;

    logic [AWIDTH-1:0] stride;
    logic              accept;
    logic              pop;
    logic              issue;
    logic              drain_done;
    logic [1:0]        fifo_cnt;
    logic [2:0]        occ;
    logic [EW-1:0]     head;

    assign accept = (state_q == IDLE) && cmd_ready_q && cmd_valid;

`ifdef BRAM_RDR_STRIDE_EN
    logic [AWIDTH-1:0] stride_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      stride_q <= '0;
        else if (accept) stride_q <= cmd_stride;
    end

    assign stride = stride_q;
`else
    assign stride = AWIDTH'(1);
`endif

    assign out_valid = (fifo_cnt != 2'd0);
    assign pop       = out_valid && out_ready;

    // Words already in the FIFO plus the one returning from the BRAM this cycle;
    // a pop this cycle frees a slot in time for the word being requested now.
    assign occ   = {1'b0, fifo_cnt} + {2'b00, inflight_q};
    assign issue = (state_q == READ) && (rem_q != '0) && (occ < (3'd2 + {2'b00, pop}));

    assign drain_done = !inflight_q && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = cmd_addr;
                    rem_d   = cmd_len;
                    state_d = (cmd_len == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (issue) begin
                    addr_d = addr_q + stride;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == (AWIDTH+1)'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            inflight_q  <= 1'b0;
            last_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            inflight_q  <= issue;
            last_q      <= issue && (rem_q == (AWIDTH+1)'(1));
            cmd_ready_q <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
        end
    end

    bram_rd_skid #(
        .W(EW)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i ({last_q, rq}),
        .pop_i       (pop),
        .count_o     (fifo_cnt),
        .head_o      (head)
    );

    assign cmd_ready   = cmd_ready_q;
    assign rce         = issue;
    assign ra          = addr_q;
    assign out_data    = head[DWIDTH-1:0];
    assign out_last    = head[DWIDTH];
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bram_sdp_stream_reader.sv
// Directed bench for bram_sdp_stream_reader with a behavioural BRAM read port.
// Stride scenarios build only when BRAM_RDR_STRIDE_EN is defined.
module tb_bram_sdp_stream_reader;

    localparam int AW = 10;
    localparam int DW = 36;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW:0]   cmd_len = '0;
    logic [AW-1:0] cmd_stride = '0;
    logic          rce;
    logic [AW-1:0] ra;
    logic [DW-1:0] rq = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_state;

    logic [DW-1:0] mem [0:1023];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (rce) rq <= mem[ra];

    bram_sdp_stream_reader #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
`ifdef BRAM_RDR_STRIDE_EN
        .cmd_stride  (cmd_stride),
`endif
        .rce         (rce),
        .ra          (ra),
        .rq          (rq),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .dbg_state_o (dbg_state)
    );

    task automatic wait_cyc();
        @(posedge clk);
        #1;
    endtask

    // Drives one command for exactly one edge; returns #1 after the accepting edge.
    task automatic send_cmd(input logic [AW-1:0] a, input logic [AW:0] l, input logic [AW-1:0] s);
        cmd_addr   = a;
        cmd_len    = l;
        cmd_stride = s;
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #3;
        n_vec++; if ({cmd_ready, rce, out_valid, out_last, busy, done} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 000000", {cmd_ready, rce, out_valid, out_last, busy, done}); end
        n_vec++; if (ra !== '0) begin n_err++; $display("FAIL reset_ra: got %0d want 0", ra); end
        n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", out_data); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_cyc();
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        mem[5] = 36'h123456789;
        out_ready = 1'b1;
        wait_cyc();
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", cmd_ready); end
        send_cmd(10'd5, 11'd1, 10'd1);
        n_vec++; if ({rce, busy} !== 2'b11) begin n_err++; $display("FAIL single_issue: rce,busy got %b want 11", {rce, busy}); end
        n_vec++; if (ra !== 10'd5) begin n_err++; $display("FAIL single_ra: got %0d want 5", ra); end
        wait_cyc();
        n_vec++; if ({rce, out_valid} !== 2'b00) begin n_err++; $display("FAIL single_n2: rce,valid got %b want 00", {rce, out_valid}); end
        wait_cyc();
        n_vec++; if ({out_valid, out_last} !== 2'b11) begin n_err++; $display("FAIL single_beat_flags: got %b want 11", {out_valid, out_last}); end
        n_vec++; if (out_data !== 36'h123456789) begin n_err++; $display("FAIL single_beat_data: got %h want 123456789", out_data); end
        wait_cyc();
        n_vec++; if ({done, out_valid, busy} !== 3'b101) begin n_err++; $display("FAIL single_done: done,valid,busy got %b want 101", {done, out_valid, busy}); end
        wait_cyc();
        n_vec++; if ({done, busy, cmd_ready} !== 3'b001) begin n_err++; $display("FAIL single_idle: done,busy,ready got %b want 001", {done, busy, cmd_ready}); end
        mem[5] = 36'd5;
    endtask

    task automatic test_stream();
        int nbeat = 0;
        int nrce = 0;
        int done_c = -1;
        out_ready = 1'b1;
        wait_cyc();
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready: got %b want 1", cmd_ready); end
        send_cmd(10'd0, 11'd16, 10'd1);
        for (int c = 0; c < 40 && done_c < 0; c++) begin
            if (c != 0) wait_cyc();
            if (rce) nrce++;
            if (out_valid) begin
                n_vec++; if (out_data !== 36'(nbeat)) begin n_err++; $display("FAIL stream_data: got %0d want %0d", out_data, nbeat); end
                n_vec++; if (out_last !== (nbeat == 15)) begin n_err++; $display("FAIL stream_last: beat %0d got %b", nbeat, out_last); end
                n_vec++; if (c != nbeat + 2) begin n_err++; $display("FAIL stream_timing: beat %0d at cycle %0d want %0d", nbeat, c, nbeat + 2); end
                nbeat++;
            end
            if (done) done_c = c;
        end
        n_vec++; if (nrce != 16) begin n_err++; $display("FAIL stream_rce_count: got %0d want 16", nrce); end
        n_vec++; if (nbeat != 16) begin n_err++; $display("FAIL stream_beats: got %0d want 16", nbeat); end
        n_vec++; if (done_c != 18) begin n_err++; $display("FAIL stream_done_cycle: got %0d want 18", done_c); end
    endtask

    task automatic test_backpressure();
        int nbeat = 0;
        int nrce = 0;
        logic got_done = 1'b0;
        logic prev_stall = 1'b0;
        logic prev_last = 1'b0;
        logic [DW-1:0] prev_data = '0;
        wait_cyc();
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready: got %b want 1", cmd_ready); end
        send_cmd(10'd0, 11'd8, 10'd1);
        for (int c = 0; c < 80 && !got_done; c++) begin
            if (c != 0) wait_cyc();
            out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            #1;
            if (prev_stall) begin
                n_vec++; if ({out_valid, out_last, out_data} !== {1'b1, prev_last, prev_data}) begin
                    n_err++; $display("FAIL bp_stable: got v=%b l=%b d=%0d want v=1 l=%b d=%0d", out_valid, out_last, out_data, prev_last, prev_data); end
            end
            if (rce) begin
                n_vec++; if ((nrce - nbeat - ((out_valid && out_ready) ? 1 : 0)) >= 2) begin
                    n_err++; $display("FAIL bp_overissue: outstanding %0d with pop %b", nrce - nbeat, out_valid && out_ready); end
                nrce++;
            end
            if (out_valid && out_ready) begin
                n_vec++; if (out_data !== 36'(nbeat)) begin n_err++; $display("FAIL bp_data: got %0d want %0d", out_data, nbeat); end
                n_vec++; if (out_last !== (nbeat == 7)) begin n_err++; $display("FAIL bp_last: beat %0d got %b", nbeat, out_last); end
                nbeat++;
            end
            prev_stall = out_valid && !out_ready;
            prev_last  = out_last;
            prev_data  = out_data;
            if (done) got_done = 1'b1;
        end
        out_ready = 1'b1;
        n_vec++; if (nbeat != 8) begin n_err++; $display("FAIL bp_beats: got %0d want 8", nbeat); end
        n_vec++; if (nrce != 8) begin n_err++; $display("FAIL bp_rce_count: got %0d want 8", nrce); end
        n_vec++; if (!got_done) begin n_err++; $display("FAIL bp_done: got 0 want 1"); end
    endtask

    task automatic test_wrap();
        int exp_a [4] = '{1022, 1023, 0, 1};
        int nbeat = 0;
        int nrce = 0;
        logic got_done = 1'b0;
        out_ready = 1'b1;
        wait_cyc();
        send_cmd(10'd1022, 11'd4, 10'd1);
        for (int c = 0; c < 40 && !got_done; c++) begin
            if (c != 0) wait_cyc();
            if (rce && nrce < 4) begin
                n_vec++; if (ra !== 10'(exp_a[nrce])) begin n_err++; $display("FAIL wrap_ra: issue %0d got %0d want %0d", nrce, ra, exp_a[nrce]); end
            end
            if (rce) nrce++;
            if (out_valid && nbeat < 4) begin
                n_vec++; if (out_data !== 36'(exp_a[nbeat])) begin n_err++; $display("FAIL wrap_data: got %0d want %0d", out_data, exp_a[nbeat]); end
            end
            if (out_valid) nbeat++;
            if (done) got_done = 1'b1;
        end
        n_vec++; if (nrce != 4 || nbeat != 4) begin n_err++; $display("FAIL wrap_counts: rce %0d beats %0d want 4 4", nrce, nbeat); end
        n_vec++; if (!got_done) begin n_err++; $display("FAIL wrap_done: got 0 want 1"); end
    endtask

    task automatic test_zero_len();
        wait_cyc();
        send_cmd(10'd7, 11'd0, 10'd1);
        n_vec++; if ({done, rce, busy, out_valid} !== 4'b1010) begin
            n_err++; $display("FAIL zero_done: done,rce,busy,valid got %b want 1010", {done, rce, busy, out_valid}); end
        wait_cyc();
        n_vec++; if ({done, rce, busy, cmd_ready} !== 4'b0001) begin
            n_err++; $display("FAIL zero_idle: done,rce,busy,ready got %b want 0001", {done, rce, busy, cmd_ready}); end
    endtask

    task automatic test_reset_mid();
        int nbeat = 0;
        int nrce = 0;
        logic got_done = 1'b0;
        out_ready = 1'b1;
        wait_cyc();
        send_cmd(10'd0, 11'd8, 10'd1);
        for (int c = 0; c < 20 && nbeat < 2; c++) begin
            if (c != 0) wait_cyc();
            if (out_valid) nbeat++;
        end
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if ({cmd_ready, rce, out_valid, out_last, busy, done} !== 6'b0) begin
            n_err++; $display("FAIL midrst_ctrl: got %b want 000000", {cmd_ready, rce, out_valid, out_last, busy, done}); end
        n_vec++; if ({ra, out_data} !== '0) begin n_err++; $display("FAIL midrst_bus: ra %0d data %0d want 0 0", ra, out_data); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_cyc();
        n_vec++; if ({cmd_ready, busy, done} !== 3'b100) begin n_err++; $display("FAIL midrst_release: ready,busy,done got %b want 100", {cmd_ready, busy, done}); end
        send_cmd(10'd3, 11'd2, 10'd1);
        nbeat = 0;
        for (int c = 0; c < 20 && !got_done; c++) begin
            if (c != 0) wait_cyc();
            if (rce) nrce++;
            if (out_valid) begin
                n_vec++; if ({out_last, out_data} !== {nbeat == 1, 36'(3 + nbeat)}) begin
                    n_err++; $display("FAIL midrst_beat: got l=%b d=%0d want l=%b d=%0d", out_last, out_data, nbeat == 1, 3 + nbeat); end
                nbeat++;
            end
            if (done) got_done = 1'b1;
        end
        n_vec++; if (nbeat != 2 || nrce != 2 || !got_done) begin
            n_err++; $display("FAIL midrst_counts: beats %0d rce %0d done %b want 2 2 1", nbeat, nrce, got_done); end
    endtask

`ifdef BRAM_RDR_STRIDE_EN
    task automatic test_stride();
        int exp_a [4] = '{0, 256, 512, 768};
        logic [AW-1:0] strides [2] = '{10'd256, 10'd0};
        mem[0] = 36'h5A5A5;
        out_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            int nbeat = 0;
            int nrce = 0;
            logic got_done = 1'b0;
            logic [DW-1:0] want;
            wait_cyc();
            send_cmd(10'd0, 11'd4, strides[t]);
            for (int c = 0; c < 30 && !got_done; c++) begin
                if (c != 0) wait_cyc();
                if (rce && nrce < 4) begin
                    n_vec++; if (ra !== ((t == 0) ? 10'(exp_a[nrce]) : 10'd0)) begin
                        n_err++; $display("FAIL stride_ra: stride %0d issue %0d got %0d", strides[t], nrce, ra); end
                end
                if (rce) nrce++;
                if (out_valid && nbeat < 4) begin
                    want = (t == 0) ? 36'(exp_a[nbeat]) : 36'h5A5A5;
                    if (t == 0 && nbeat == 0) want = 36'h5A5A5;
                    n_vec++; if (out_data !== want) begin n_err++; $display("FAIL stride_data: got %h want %h", out_data, want); end
                end
                if (out_valid) nbeat++;
                if (done) got_done = 1'b1;
            end
            n_vec++; if (nrce != 4 || nbeat != 4 || !got_done) begin
                n_err++; $display("FAIL stride_counts: rce %0d beats %0d done %b want 4 4 1", nrce, nbeat, got_done); end
        end
        mem[0] = 36'd0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 36'(i);
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_reset_mid();
`ifdef BRAM_RDR_STRIDE_EN
        test_stride();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
